// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: WB stage vs. a one-entry buffered AUX result, with a pending-write scoreboard.
// Optional ARB_PERF_EN adds saturating FORCE / AUX-wait cycle counters.
module rf_write_arbiter #(
  parameter int REGISTERWIDTH  = 5,
  parameter int DATA           = 32,
  parameter int REGISTERNUMBER = 32,
  parameter int STARVE_LIMIT   = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wb_valid,
  input  logic [REGISTERWIDTH-1:0]  wb_rd,
  input  logic [DATA-1:0]           wb_data,
  input  logic                      aux_valid,
  output logic                      aux_ready,
  input  logic [REGISTERWIDTH-1:0]  aux_rd,
  input  logic [DATA-1:0]           aux_data,
  input  logic                      issue_valid,
  input  logic [REGISTERWIDTH-1:0]  issue_rd,
  output logic                      rf_we,
  output logic [REGISTERWIDTH-1:0]  rf_rd,
  output logic [DATA-1:0]           rf_wdata,
  output logic                      pipe_stall,
`ifdef ARB_PERF_EN
  output logic [15:0]               perf_force_cnt,
  output logic [15:0]               perf_aux_wait_cnt,
`endif
  output logic [REGISTERNUMBER-1:0] busy_vec
);

  typedef enum logic [1:0] {EMPTY, PENDING, FORCE} state_t;

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  state_t                    state_reg, state_next;
  logic [REGISTERWIDTH-1:0]  hold_rd_reg, hold_rd_next;
  logic [DATA-1:0]           hold_data_reg, hold_data_next;
  logic [3:0]                starve_cnt_reg, starve_cnt_next;
  logic [REGISTERNUMBER-1:0] busy_reg, busy_next;
  logic                      hold_grant;

  always_comb begin
    state_next      = state_reg;
    hold_rd_next    = hold_rd_reg;
    hold_data_next  = hold_data_reg;
    starve_cnt_next = starve_cnt_reg;
    hold_grant      = 1'b0;
    aux_ready       = 1'b0;
    pipe_stall      = 1'b0;
    case (state_reg)
      EMPTY: begin
        aux_ready = 1'b1;
        // r0 results are accepted but never buffered
        if (aux_valid && (aux_rd != '0)) begin
          hold_rd_next    = aux_rd;
          hold_data_next  = aux_data;
          starve_cnt_next = '0;
          state_next      = PENDING;
        end
      end
      PENDING: begin
        if (!wb_valid) begin
          hold_grant = 1'b1;
          state_next = EMPTY;
        end else begin
          starve_cnt_next = starve_cnt_reg + 4'd1;
          if (starve_cnt_next == STARVE_MAX) begin
            state_next = FORCE;
          end
        end
      end
      FORCE: begin
        pipe_stall = 1'b1;
        hold_grant = 1'b1;
        state_next = EMPTY;
      end
      default: state_next = EMPTY;
    endcase
  end

  always_comb begin
    if (hold_grant) begin
      rf_we    = (hold_rd_reg != '0);
      rf_rd    = hold_rd_reg;
      rf_wdata = hold_data_reg;
    end else begin
      rf_we    = wb_valid && (wb_rd != '0);
      rf_rd    = wb_rd;
      rf_wdata = wb_data;
    end
  end

  // Per-register scoreboard: a new issue overrides the clear from a same-cycle hold write
  genvar gi;
  generate
    for (gi = 0; gi < REGISTERNUMBER; gi++) begin : g_busy
      if (gi == 0) begin : g_zero
        assign busy_next[gi] = 1'b0;
      end else begin : g_bit
        logic set_bit;
        logic clr_bit;
        assign set_bit       = issue_valid && (issue_rd == REGISTERWIDTH'(gi));
        assign clr_bit       = hold_grant && (hold_rd_reg == REGISTERWIDTH'(gi));
        assign busy_next[gi] = set_bit | (busy_reg[gi] & ~clr_bit);
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= EMPTY;
      hold_rd_reg    <= '0;
      hold_data_reg  <= '0;
      starve_cnt_reg <= '0;
      busy_reg       <= '0;
    end else begin
      state_reg      <= state_next;
      hold_rd_reg    <= hold_rd_next;
      hold_data_reg  <= hold_data_next;
      starve_cnt_reg <= starve_cnt_next;
      busy_reg       <= busy_next;
    end
  end

  assign busy_vec = busy_reg;

`ifdef ARB_PERF_EN
  logic [15:0] perf_force_reg;
  logic [15:0] perf_wait_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_force_reg <= '0;
      perf_wait_reg  <= '0;
    end else begin
      if ((state_reg == FORCE) && (perf_force_reg != 16'hFFFF)) begin
        perf_force_reg <= perf_force_reg + 16'd1;
      end
      if ((state_reg == PENDING) && wb_valid && (perf_wait_reg != 16'hFFFF)) begin
        perf_wait_reg <= perf_wait_reg + 16'd1;
      end
    end
  end

  assign perf_force_cnt    = perf_force_reg;
  assign perf_aux_wait_cnt = perf_wait_reg;
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: directed scenarios plus randomized traffic against a rule-level model.
module tb_rf_write_arbiter;

  localparam int RW = 5;
  localparam int DW = 32;
  localparam int RN = 32;
  localparam int SL = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          wb_valid;
  logic [RW-1:0] wb_rd;
  logic [DW-1:0] wb_data;
  logic          aux_valid;
  logic          aux_ready;
  logic [RW-1:0] aux_rd;
  logic [DW-1:0] aux_data;
  logic          issue_valid;
  logic [RW-1:0] issue_rd;
  logic          rf_we;
  logic [RW-1:0] rf_rd;
  logic [DW-1:0] rf_wdata;
  logic          pipe_stall;
  logic [RN-1:0] busy_vec;
`ifdef ARB_PERF_EN
  logic [15:0]   perf_force_cnt;
  logic [15:0]   perf_aux_wait_cnt;
`endif

  int checks = 0;
  int errors = 0;

  rf_write_arbiter #(
    .REGISTERWIDTH (RW),
    .DATA          (DW),
    .REGISTERNUMBER(RN),
    .STARVE_LIMIT  (SL)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .wb_valid   (wb_valid),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .aux_valid  (aux_valid),
    .aux_ready  (aux_ready),
    .aux_rd     (aux_rd),
    .aux_data   (aux_data),
    .issue_valid(issue_valid),
    .issue_rd   (issue_rd),
    .rf_we      (rf_we),
    .rf_rd      (rf_rd),
    .rf_wdata   (rf_wdata),
    .pipe_stall (pipe_stall),
`ifdef ARB_PERF_EN
    .perf_force_cnt   (perf_force_cnt),
    .perf_aux_wait_cnt(perf_aux_wait_cnt),
`endif
    .busy_vec   (busy_vec)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #4;
  endtask

  task automatic idle_inputs;
    wb_valid    = 1'b0;
    wb_rd       = '0;
    wb_data     = '0;
    aux_valid   = 1'b0;
    aux_rd      = '0;
    aux_data    = '0;
    issue_valid = 1'b0;
    issue_rd    = '0;
  endtask

  task automatic apply_reset;
    reset = 1'b0;
    idle_inputs();
    repeat (2) tick();
    reset = 1'b1;
  endtask

  task automatic test_reset;
    apply_reset();
    settle();
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_rf_we: got %b expected 0", rf_we); end
    checks++; if (pipe_stall !== 1'b0) begin errors++; $display("FAIL reset_pipe_stall: got %b expected 0", pipe_stall); end
    checks++; if (aux_ready !== 1'b1) begin errors++; $display("FAIL reset_aux_ready: got %b expected 1", aux_ready); end
    checks++; if (busy_vec !== '0) begin errors++; $display("FAIL reset_busy_vec: got %h expected 0", busy_vec); end
    $display("reset: outputs idle, busy_vec=%h", busy_vec);
    tick();
  endtask

  task automatic test_basic_aux_write;
    idle_inputs();
    issue_valid = 1'b1; issue_rd = 5'd7;
    settle(); tick();
    issue_valid = 1'b0;
    aux_valid = 1'b1; aux_rd = 5'd7; aux_data = 32'h1234;
    settle();
    checks++; if (aux_ready !== 1'b1) begin errors++; $display("FAIL basic_accept_ready: got %b expected 1", aux_ready); end
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL basic_accept_we: got %b expected 0", rf_we); end
    checks++; if (busy_vec[7] !== 1'b1) begin errors++; $display("FAIL basic_busy_set: got %b expected 1", busy_vec[7]); end
    tick();
    aux_valid = 1'b0;
    settle();
    checks++; if (rf_we !== 1'b1) begin errors++; $display("FAIL basic_write_we: got %b expected 1", rf_we); end
    checks++; if (rf_rd !== 5'd7) begin errors++; $display("FAIL basic_write_rd: got %0d expected 7", rf_rd); end
    checks++; if (rf_wdata !== 32'h1234) begin errors++; $display("FAIL basic_write_data: got %h expected 00001234", rf_wdata); end
    checks++; if (aux_ready !== 1'b0) begin errors++; $display("FAIL basic_write_ready: got %b expected 0", aux_ready); end
    tick();
    settle();
    checks++; if (busy_vec[7] !== 1'b0) begin errors++; $display("FAIL basic_busy_clear: got %b expected 0", busy_vec[7]); end
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL basic_after_we: got %b expected 0", rf_we); end
    checks++; if (aux_ready !== 1'b1) begin errors++; $display("FAIL basic_after_ready: got %b expected 1", aux_ready); end
    $display("basic: aux write r7=00001234 one cycle after accept");
    tick();
  endtask

  task automatic test_starve_force;
    logic [DW-1:0] hold_val;
    logic [DW-1:0] retry_val;
    idle_inputs();
    hold_val = $urandom;
    aux_valid = 1'b1; aux_rd = 5'd9; aux_data = hold_val;
    settle(); tick();
    aux_valid = 1'b0;
    wb_valid = 1'b1; wb_rd = 5'd3;
    for (int i = 0; i < SL; i++) begin
      wb_data = $urandom;
      settle();
      checks++; if (rf_we !== 1'b1 || rf_rd !== 5'd3 || rf_wdata !== wb_data) begin
        errors++; $display("FAIL starve_wb_grant[%0d]: got we=%b rd=%0d data=%h expected we=1 rd=3 data=%h", i, rf_we, rf_rd, rf_wdata, wb_data);
      end
      checks++; if (pipe_stall !== 1'b0) begin errors++; $display("FAIL starve_no_stall[%0d]: got %b expected 0", i, pipe_stall); end
      tick();
    end
    retry_val = 32'hCAFE_0003;
    wb_data = retry_val;
    settle();
    checks++; if (pipe_stall !== 1'b1) begin errors++; $display("FAIL starve_force_stall: got %b expected 1", pipe_stall); end
    checks++; if (rf_we !== 1'b1 || rf_rd !== 5'd9 || rf_wdata !== hold_val) begin
      errors++; $display("FAIL starve_force_write: got we=%b rd=%0d data=%h expected we=1 rd=9 data=%h", rf_we, rf_rd, rf_wdata, hold_val);
    end
    tick();
    settle();
    checks++; if (pipe_stall !== 1'b0) begin errors++; $display("FAIL starve_retry_stall: got %b expected 0", pipe_stall); end
    checks++; if (rf_we !== 1'b1 || rf_rd !== 5'd3 || rf_wdata !== retry_val) begin
      errors++; $display("FAIL starve_retry_write: got we=%b rd=%0d data=%h expected we=1 rd=3 data=%h", rf_we, rf_rd, rf_wdata, retry_val);
    end
    checks++; if (aux_ready !== 1'b1) begin errors++; $display("FAIL starve_retry_ready: got %b expected 1", aux_ready); end
    $display("starve: %0d WB writes, forced r9=%h, WB retry landed", SL, hold_val);
    tick();
    idle_inputs();
  endtask

  task automatic test_r0_writes;
    idle_inputs();
    aux_valid = 1'b1; aux_rd = 5'd0; aux_data = $urandom;
    wb_valid = 1'b1; wb_rd = 5'd0; wb_data = $urandom;
    settle();
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL r0_first_we: got %b expected 0", rf_we); end
    checks++; if (aux_ready !== 1'b1) begin errors++; $display("FAIL r0_first_ready: got %b expected 1", aux_ready); end
    tick();
    aux_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wb_valid = (i < 2);
      settle();
      checks++; if (rf_we !== 1'b0 || aux_ready !== 1'b1 || pipe_stall !== 1'b0) begin
        errors++; $display("FAIL r0_follow[%0d]: got we=%b ready=%b stall=%b expected we=0 ready=1 stall=0", i, rf_we, aux_ready, pipe_stall);
      end
      tick();
    end
    $display("r0: aux and wb writes to r0 suppressed, state stayed EMPTY");
    idle_inputs();
  endtask

  task automatic test_set_wins;
    idle_inputs();
    issue_valid = 1'b1; issue_rd = 5'd5;
    settle(); tick();
    issue_valid = 1'b0;
    aux_valid = 1'b1; aux_rd = 5'd5; aux_data = 32'h5555_AAAA;
    settle(); tick();
    aux_valid = 1'b0;
    issue_valid = 1'b1; issue_rd = 5'd5;
    settle();
    checks++; if (rf_we !== 1'b1 || rf_rd !== 5'd5) begin
      errors++; $display("FAIL setwins_write: got we=%b rd=%0d expected we=1 rd=5", rf_we, rf_rd);
    end
    tick();
    issue_valid = 1'b0;
    settle();
    checks++; if (busy_vec[5] !== 1'b1) begin errors++; $display("FAIL setwins_busy5: got %b expected 1", busy_vec[5]); end
    $display("set_wins: r5 written and re-issued same cycle, busy_vec[5]=%b", busy_vec[5]);
    tick();
  endtask

  task automatic test_midop_reset;
    apply_reset();
    issue_valid = 1'b1; issue_rd = 5'd3;
    settle(); tick();
    issue_valid = 1'b0;
    aux_valid = 1'b1; aux_rd = 5'd3; aux_data = 32'hDEAD_0003;
    settle(); tick();
    aux_valid = 1'b0;
    wb_valid = 1'b1; wb_rd = 5'd4; wb_data = 32'h0000_0044;
    settle();
    checks++; if (aux_ready !== 1'b0 || busy_vec[3] !== 1'b1) begin
      errors++; $display("FAIL midreset_pending: got ready=%b busy3=%b expected ready=0 busy3=1", aux_ready, busy_vec[3]);
    end
    #1 reset = 1'b0;
    #1;
    checks++; if (busy_vec !== '0) begin errors++; $display("FAIL midreset_busy_clear: got %h expected 0", busy_vec); end
    checks++; if (aux_ready !== 1'b1) begin errors++; $display("FAIL midreset_ready: got %b expected 1", aux_ready); end
    tick();
    idle_inputs();
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      settle();
      checks++; if (rf_we !== 1'b0 || aux_ready !== 1'b1) begin
        errors++; $display("FAIL midreset_after[%0d]: got we=%b rd=%0d ready=%b expected we=0 ready=1", i, rf_we, rf_rd, aux_ready);
      end
      tick();
    end
    $display("midreset: buffered r3 dropped, busy_vec cleared");
  endtask

  // Model: one held result, a count of WB grants it has lost, and a busy bit per register.
  task automatic test_random;
    bit            m_hv;
    logic [RW-1:0] m_hrd;
    logic [DW-1:0] m_hdata;
    int            m_blocked;
    logic [RN-1:0] m_busy;
    bit            prev_stall;
    bit            forced, hold_wr, exp_we;
    logic [RW-1:0] exp_rd;
    logic [DW-1:0] exp_data;
    int            forces;
    apply_reset();
    m_hv = 0; m_hrd = '0; m_hdata = '0; m_blocked = 0; m_busy = '0;
    prev_stall = 0; forces = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (!prev_stall) begin
        wb_valid = ($urandom_range(0, 99) < 70);
        wb_rd    = RW'($urandom_range(0, RN - 1));
        wb_data  = $urandom;
      end
      aux_valid   = ($urandom_range(0, 99) < 40);
      aux_rd      = RW'($urandom_range(0, RN - 1));
      aux_data    = $urandom;
      issue_valid = ($urandom_range(0, 99) < 30);
      issue_rd    = RW'($urandom_range(0, RN - 1));
      settle();

      forced  = m_hv && (m_blocked == SL);
      hold_wr = forced || (m_hv && !wb_valid);
      if (hold_wr) begin
        exp_we = 1'b1; exp_rd = m_hrd; exp_data = m_hdata;
      end else begin
        exp_we = wb_valid && (wb_rd != 0); exp_rd = wb_rd; exp_data = wb_data;
      end

      checks++; if (rf_we !== exp_we) begin errors++; $display("FAIL rnd_we cyc=%0d: got %b expected %b", cyc, rf_we, exp_we); end
      if (exp_we) begin
        checks++; if (rf_rd !== exp_rd || rf_wdata !== exp_data) begin
          errors++; $display("FAIL rnd_write cyc=%0d: got rd=%0d data=%h expected rd=%0d data=%h", cyc, rf_rd, rf_wdata, exp_rd, exp_data);
        end
      end
      checks++; if (pipe_stall !== forced) begin errors++; $display("FAIL rnd_stall cyc=%0d: got %b expected %b", cyc, pipe_stall, forced); end
      checks++; if (aux_ready !== !m_hv) begin errors++; $display("FAIL rnd_ready cyc=%0d: got %b expected %b", cyc, aux_ready, !m_hv); end
      checks++; if (busy_vec !== m_busy) begin errors++; $display("FAIL rnd_busy cyc=%0d: got %h expected %h", cyc, busy_vec, m_busy); end
      if (hold_wr) $display("rnd cyc=%0d: aux write r%0d=%h forced=%0d", cyc, m_hrd, m_hdata, forced);

      if (hold_wr) m_busy[m_hrd] = 1'b0;
      if (issue_valid && issue_rd != 0) m_busy[issue_rd] = 1'b1;
      if (hold_wr) begin
        m_hv = 0;
      end else if (m_hv) begin
        m_blocked++;
      end else if (aux_valid && aux_rd != 0) begin
        m_hv = 1; m_hrd = aux_rd; m_hdata = aux_data; m_blocked = 0;
      end
      if (forced) forces++;
      prev_stall = forced;
      tick();
    end
    $display("random: 600 cycles, %0d forced writes", forces);
    idle_inputs();
  endtask

  initial begin
    reset = 1'b0;
    idle_inputs();
    test_reset();
    test_basic_aux_write();
    test_starve_force();
    test_r0_writes();
    test_set_wins();
    test_midop_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
